csi2_packet_tx: RTL and testbench
=================================

CSI2_PACKET_TX -- requirements
Module: csi2_packet_tx

Interface
REQ-001 SHALL have parameter TRAIL_BYTES, default 1, number of HS trail bytes appended after each packet (range 1..4).
REQ-002 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  in  1  request one packet; sampled only while ready=1.
REQ-005 SHALL have port short_pkt  in  1  1 = short packet (no payload/footer), 0 = long packet.
REQ-006 SHALL have port data_id  in  8  {VC[1:0], DT[5:0]}, captured with start.
REQ-007 SHALL have port word_count  in  16  payload byte count (long) or data field (short), captured with start.
REQ-008 SHALL have port ready  out  1  idle, start accepted.
REQ-009 SHALL have port pl_data  in  8  payload byte.
REQ-010 SHALL have port pl_valid  in  1  pl_data valid.
REQ-011 SHALL have port pl_ready  out  1  payload byte consumed this cycle when pl_valid=1.
REQ-012 SHALL have port tx_byte  out  8  lane byte, LSB transmitted first.
REQ-013 SHALL have port tx_hs_req  out  1  HS burst request; high for every cycle tx_byte is meaningful.
REQ-014 SHALL have port done  out  1  one-cycle pulse on final trail byte.
REQ-015 SHALL have port underrun  out  1  sticky; payload starvation seen; cleared only by reset.

Function
REQ-016 SHALL implement states IDLE, SYNC, DI, WC_L, WC_H, ECC, PAYLOAD, CRC_L, CRC_H, TRAIL; ready=1 only in IDLE.
REQ-017 SHALL on start&ready in cycle N present 0xB8 (SYNC) with tx_hs_req=1 in cycle N+1, then data_id, WC[7:0], WC[15:8], ECC in N+2..N+5.
REQ-018 SHALL compute ECC as the CSI-2 6-bit Hamming code over {WC[15:0],DI[7:0]} (d0 = DI bit 0); ECC byte bits 7:6 = 0.
REQ-019 SHALL after ECC go to TRAIL for short packets, to PAYLOAD for long packets with WC>0, to CRC_L for WC=0.
REQ-020 SHALL in PAYLOAD emit exactly WC bytes, one per cycle, counted with a 16-bit down-counter; WC=0xFFFF is legal.
REQ-021 SHALL drive pl_ready=1 in the ECC cycle and every PAYLOAD cycle except the last, when long and WC>0; the consumed byte appears on tx_byte next cycle.
REQ-022 SHALL on pl_ready=1 with pl_valid=0 set underrun, emit 0x00 in place of the byte, include 0x00 in the CRC, and continue without stalling.
REQ-023 SHALL compute CRC-16 over payload bytes only: poly x^16+x^12+x^5+1, reflected (0x8408), init 0xFFFF, LSB-first, no final XOR; emit CRC[7:0] then CRC[15:8].
REQ-024 SHALL emit TRAIL_BYTES trail bytes, each all bits equal to the inverse of bit 7 of the previous transmitted byte; done=1 on the last one, IDLE next cycle.
REQ-025 SHALL ignore start while ready=0; start in the cycle IDLE is re-entered is accepted with no gap.
REQ-026 SHALL hold tx_byte=0x00 and tx_hs_req=0 in IDLE.

Reset
REQ-027 SHALL on rst_n=0 at any clock edge, including mid-packet, enter IDLE with tx_byte=0x00, tx_hs_req=0, pl_ready=0, done=0, underrun=0, ready=1 from the following cycle; partial packet abandoned, CRC reinitialised to 0xFFFF.

Structure
REQ-028 SHALL place SYNC_BYTE (0xB8), data-type constants, the ECC function and the byte-wise CRC step function in shared package csi2_pkg.
REQ-029 SHALL use one sub-module csi2_crc16 (clear, byte-enable, 8-bit data, 16-bit crc out) instantiated once.

Verification
REQ-030 SHALL cover short packet DI=0x01, WC=0x0000 -> tx bytes B8 01 00 00 07 then trail 0xFF, done on trail, total 6 hs cycles.
REQ-031 SHALL cover long packet DI=0x2B, 24 bytes FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 -> footer F0 00, trail 0xFF.
REQ-032 SHALL cover long packet WC=0 -> B8 DI 00 00 ECC FF FF then trail 0x00, pl_ready never asserted.
REQ-033 SHALL cover pl_valid dropped on payload byte 3 of 8 -> 0x00 emitted there, underrun=1 and held, CRC matches model with 0x00 substituted.
REQ-034 SHALL cover rst_n low during PAYLOAD -> next cycle tx_hs_req=0, ready=1; following packet DI=0x00 WC=0 short yields B8 00 00 00 00 FF.
REQ-035 SHALL cover back-to-back start held high for two packets with TRAIL_BYTES=2 -> second SYNC in cycle immediately after first IDLE cycle, start ignored while busy.

Source files
------------

// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: sync byte, data types, packet FSM states,
// and the ECC / CRC helper functions used by the transmitter.
package csi2_pkg;

    localparam logic [7:0]  SYNC_BYTE      = 8'hB8;

    localparam logic [5:0]  DT_FRAME_START = 6'h00;
    localparam logic [5:0]  DT_FRAME_END   = 6'h01;
    localparam logic [5:0]  DT_LINE_START  = 6'h02;
    localparam logic [5:0]  DT_LINE_END    = 6'h03;
    localparam logic [5:0]  DT_YUV422_8    = 6'h1E;
    localparam logic [5:0]  DT_RAW8        = 6'h2A;
    localparam logic [5:0]  DT_RAW10       = 6'h2B;
    localparam logic [5:0]  DT_RAW12       = 6'h2C;

    localparam logic [15:0] CRC_INIT       = 16'hFFFF;
    localparam logic [15:0] CRC_POLY       = 16'h8408;

    typedef enum logic [3:0] {
        IDLE, SYNC, DI, WC_L, WC_H, ECC, PAYLOAD, CRC_L, CRC_H, TRAIL
    } state_t;

    // 6-bit Hamming ECC over the 24-bit header {WC, DI}; d[0] is DI bit 0.
    function automatic logic [7:0] ecc_calc(input logic [7:0] di, input logic [15:0] wc);
        logic [23:0] d;
        logic [5:0]  p;
        d = {wc, di};
        p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^ d[11] ^ d[13] ^ d[16]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^ d[12] ^ d[14] ^ d[17]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^ d[12] ^ d[15] ^ d[18]
             ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^ d[14] ^ d[15] ^ d[19]
             ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^ d[17] ^ d[18] ^ d[19]
             ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
             ^ d[21] ^ d[22] ^ d[23];
        return {2'b00, p};
    endfunction

    // One byte of reflected CRC-16 (poly 0x8408), data consumed LSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/csi2_crc16.sv
// Byte-wide payload CRC accumulator; clear has priority over enable.
module csi2_crc16
    import csi2_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    // Accumulate one payload byte per enabled cycle, restart on clear.
    always_ff @(posedge clk) begin
        if (clear)   crc <= CRC_INIT;
        else if (en) crc <= crc16_step(crc, data);
    end

endmodule

// File: rtl/csi2_packet_tx.sv
// CSI-2 packet serialiser: header, optional payload with CRC footer,
// and HS trail bytes onto a single byte lane.
module csi2_packet_tx
    import csi2_pkg::*;
#(
    parameter int TRAIL_BYTES = 1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        short_pkt,
    input  logic [7:0]  data_id,
    input  logic [15:0] word_count,
    output logic        ready,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_hs_req,
    output logic        done,
    output logic        underrun
);

    state_t      state, state_nx;
    logic [7:0]  di_r;
    logic [15:0] wc_r;
    logic        short_r;
    logic [15:0] pay_cnt;
    logic [2:0]  trail_cnt;
    logic [7:0]  pay_byte_p1;
    logic        prev_b7;
    logic [15:0] crc;
    logic        accept;
    logic [7:0]  pl_eff;

    assign accept = start & ready;
    // A starved payload slot is replaced by 0x00 both on the lane and in the CRC.
    assign pl_eff = pl_valid ? pl_data : 8'h00;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SYNC;
            SYNC:    state_nx = DI;
            DI:      state_nx = WC_L;
            WC_L:    state_nx = WC_H;
            WC_H:    state_nx = ECC;
            ECC: begin
                if (short_r)           state_nx = TRAIL;
                else if (wc_r == '0)   state_nx = CRC_L;
                else                   state_nx = PAYLOAD;
            end
            PAYLOAD: if (pay_cnt == 16'd1) state_nx = CRC_L;
            CRC_L:   state_nx = CRC_H;
            CRC_H:   state_nx = TRAIL;
            TRAIL:   if (trail_cnt == 3'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane byte, handshakes and done pulse decoded from the current state.
    always_comb begin
        ready     = 1'b0;
        tx_byte   = 8'h00;
        tx_hs_req = 1'b1;
        pl_ready  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready     = 1'b1;
                tx_hs_req = 1'b0;
            end
            SYNC:    tx_byte = SYNC_BYTE;
            DI:      tx_byte = di_r;
            WC_L:    tx_byte = wc_r[7:0];
            WC_H:    tx_byte = wc_r[15:8];
            ECC: begin
                tx_byte  = ecc_calc(di_r, wc_r);
                pl_ready = ~short_r & (wc_r != '0);
            end
            PAYLOAD: begin
                tx_byte  = pay_byte_p1;
                pl_ready = (pay_cnt != 16'd1);
            end
            CRC_L:   tx_byte = crc[7:0];
            CRC_H:   tx_byte = crc[15:8];
            TRAIL: begin
                tx_byte = {8{~prev_b7}};
                done    = (trail_cnt == 3'd0);
            end
            default: tx_hs_req = 1'b0;
        endcase
    end

    // Sticky starvation flag.
    always_ff @(posedge clk) begin
        if (!rst_n)                   underrun <= 1'b0;
        else if (pl_ready & ~pl_valid) underrun <= 1'b1;
    end

    // Header capture, payload/trail counters and lane history; loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            di_r    <= data_id;
            wc_r    <= word_count;
            short_r <= short_pkt;
        end
        if (state == ECC)          pay_cnt <= wc_r;
        else if (state == PAYLOAD) pay_cnt <= pay_cnt - 16'd1;
        if (state != TRAIL && state_nx == TRAIL) trail_cnt <= 3'(TRAIL_BYTES - 1);
        else if (state == TRAIL)                 trail_cnt <= trail_cnt - 3'd1;
        if (pl_ready) pay_byte_p1 <= pl_eff;
        prev_b7 <= tx_byte[7];
    end

    csi2_crc16 u_crc (
        .clk   (clk),
        .clear (~rst_n | accept),
        .en    (pl_ready),
        .data  (pl_eff),
        .crc   (crc)
    );

endmodule

// File: tb/tb_csi2_packet_tx.sv
// Randomised bench for csi2_packet_tx against a packet-level reference model.
module tb_csi2_packet_tx;

    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    logic        clk;
    logic        rst_n;
    logic        start      [2];
    logic        short_pkt  [2];
    logic [7:0]  data_id    [2];
    logic [15:0] word_count [2];
    logic        ready      [2];
    logic [7:0]  pl_data    [2];
    logic        pl_valid   [2];
    logic        pl_ready   [2];
    logic [7:0]  tx_byte    [2];
    logic        tx_hs_req  [2];
    logic        done       [2];
    logic        underrun   [2];

    int          n_chk;
    int          n_fail;
    logic [15:0] crc_tab [256];
    logic [7:0]  pay_q [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    logic [7:0]  lit_q [$];
    bit          ul_exp [2];

    csi2_packet_tx #(.TRAIL_BYTES(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .short_pkt(short_pkt[0]),
        .data_id(data_id[0]), .word_count(word_count[0]), .ready(ready[0]),
        .pl_data(pl_data[0]), .pl_valid(pl_valid[0]), .pl_ready(pl_ready[0]),
        .tx_byte(tx_byte[0]), .tx_hs_req(tx_hs_req[0]), .done(done[0]), .underrun(underrun[0])
    );

    csi2_packet_tx #(.TRAIL_BYTES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .short_pkt(short_pkt[1]),
        .data_id(data_id[1]), .word_count(word_count[1]), .ready(ready[1]),
        .pl_data(pl_data[1]), .pl_valid(pl_valid[1]), .pl_ready(pl_ready[1]),
        .tx_byte(tx_byte[1]), .tx_hs_req(tx_hs_req[1]), .done(done[1]), .underrun(underrun[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic logic [7:0] ecc_model(input logic [7:0] di, input logic [15:0] wc);
        logic [23:0] d;
        logic [5:0]  e;
        d = {wc, di};
        e = '0;
        for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_COL[i];
        return {2'b00, e};
    endfunction

    // Expected lane stream of one packet, built from the packet rules.
    function automatic void build_exp(input int s, input bit shrt, input logic [7:0] di,
                                      input logic [15:0] wc, input int drop);
        logic [15:0] c;
        logic [7:0]  b;
        logic [7:0]  prev;
        exp_q.delete();
        exp_q.push_back(8'hB8);
        exp_q.push_back(di);
        exp_q.push_back(wc[7:0]);
        exp_q.push_back(wc[15:8]);
        exp_q.push_back(ecc_model(di, wc));
        if (!shrt) begin
            c = 16'hFFFF;
            for (int i = 0; i < int'(wc); i++) begin
                b = (i == drop) ? 8'h00 : pay_q[i];
                exp_q.push_back(b);
                c = (c >> 8) ^ crc_tab[c[7:0] ^ b];
            end
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end
        prev = exp_q[exp_q.size() - 1];
        for (int t = 0; t < ((s == 0) ? 1 : 2); t++) begin
            b = prev[7] ? 8'h00 : 8'hFF;
            exp_q.push_back(b);
            prev = b;
        end
    endfunction

    task automatic fill_rand(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic chk_lit(input string tag);
        chk({tag, "_len"}, got_q.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_lit[%0d]", tag, i), got_q[i], lit_q[i]);
    endtask

    // Send one packet on DUT s, drive payload on demand, compare against the model.
    task automatic run_pkt(input int s, input bit shrt, input logic [7:0] di,
                           input logic [15:0] wc, input int drop, input string tag);
        int  k, n_prdy, n_done, gaps, limit;
        bit  finished;
        build_exp(s, shrt, di, wc, drop);
        got_q.delete();
        k = 0; n_prdy = 0; n_done = 0; gaps = 0; finished = 0;
        limit = shrt ? 64 : int'(wc) + 64;
        chk({tag, "_ready_before"}, ready[s], 1'b1);
        start[s] = 1'b1; short_pkt[s] = shrt; data_id[s] = di; word_count[s] = wc;
        @(negedge clk);
        start[s] = 1'b0; short_pkt[s] = 1'($urandom); data_id[s] = 8'($urandom);
        word_count[s] = 16'($urandom);
        for (int cyc = 0; cyc < limit && !finished; cyc++) begin
            if (!tx_hs_req[s]) gaps++;
            else               got_q.push_back(tx_byte[s]);
            if (done[s]) begin
                n_done++;
                finished = 1;
            end
            if (pl_ready[s]) begin
                n_prdy++;
                pl_data[s]  = (k < pay_q.size()) ? pay_q[k] : 8'h5A;
                pl_valid[s] = (k != drop);
                k++;
            end else begin
                pl_data[s]  = 8'($urandom);
                pl_valid[s] = 1'($urandom);
            end
            @(negedge clk);
        end
        pl_valid[s] = 1'b0;
        if (!shrt && drop >= 0 && drop < int'(wc)) ul_exp[s] = 1'b1;
        chk({tag, "_done_seen"}, finished, 1'b1);
        chk({tag, "_hs_gaps"}, gaps, 0);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte[%0d]", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_pl_ready_cnt"}, n_prdy, shrt ? 0 : int'(wc));
        chk({tag, "_idle_hs"}, tx_hs_req[s], 1'b0);
        chk({tag, "_idle_ready"}, ready[s], 1'b1);
        chk({tag, "_idle_byte"}, tx_byte[s], 8'h00);
        chk({tag, "_underrun"}, underrun[s], ul_exp[s]);
    endtask

    task automatic chk_idle(input int s, input string tag);
        chk({tag, "_ready"}, ready[s], 1'b1);
        chk({tag, "_hs"}, tx_hs_req[s], 1'b0);
        chk({tag, "_byte"}, tx_byte[s], 8'h00);
        chk({tag, "_pl_ready"}, pl_ready[s], 1'b0);
        chk({tag, "_done"}, done[s], 1'b0);
        chk({tag, "_underrun"}, underrun[s], 1'b0);
    endtask

    // Two packets with start held high; second SYNC right after one idle cycle.
    task automatic run_b2b();
        logic [7:0]  di_a, di_b;
        logic [15:0] wc_a, wc_b;
        logic [9:0]  tr_exp [$];
        logic [9:0]  tr_got [$];
        di_a = 8'($urandom); di_b = 8'($urandom);
        wc_a = 16'($urandom); wc_b = 16'($urandom);
        build_exp(1, 1'b1, di_a, wc_a, -1);
        foreach (exp_q[i]) tr_exp.push_back({2'b01, exp_q[i]});
        tr_exp.push_back({2'b10, 8'h00});
        build_exp(1, 1'b1, di_b, wc_b, -1);
        foreach (exp_q[i]) tr_exp.push_back({2'b01, exp_q[i]});
        repeat (3) tr_exp.push_back({2'b10, 8'h00});
        start[1] = 1'b1; short_pkt[1] = 1'b1; data_id[1] = di_a; word_count[1] = wc_a;
        for (int c = 0; c < tr_exp.size(); c++) begin
            @(negedge clk);
            tr_got.push_back({ready[1], tx_hs_req[1], tx_byte[1]});
            if (c == 0) begin
                data_id[1]    = di_b;
                word_count[1] = wc_b;
            end
            if (c == 8) start[1] = 1'b0;
        end
        for (int i = 0; i < tr_exp.size(); i++)
            chk($sformatf("b2b_cycle[%0d]", i), tr_got[i], tr_exp[i]);
    endtask

    initial begin
        logic [15:0] c;
        bit          shrt;
        logic [15:0] wc;
        int          drop;
        n_chk = 0; n_fail = 0;
        ul_exp[0] = 0; ul_exp[1] = 0;
        for (int n = 0; n < 256; n++) begin
            c = 16'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
            crc_tab[n] = c;
        end
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start[s] = 0; short_pkt[s] = 0; data_id[s] = 0; word_count[s] = 0;
            pl_data[s] = 0; pl_valid[s] = 0;
        end
        repeat (3) @(negedge clk);
        chk_idle(0, "reset0");
        chk_idle(1, "reset1");
        rst_n = 1'b1;
        @(negedge clk);

        // Short packet, literal vector.
        run_pkt(0, 1'b1, 8'h01, 16'h0000, -1, "short01");
        lit_q = '{8'hB8, 8'h01, 8'h00, 8'h00, 8'h07, 8'hFF};
        chk_lit("short01");

        // Long packet with the reference payload and footer.
        pay_q = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4,
                  8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF,
                  8'hFF, 8'h00, 8'h00, 8'h01};
        run_pkt(0, 1'b0, 8'h2B, 16'd24, -1, "long24");
        lit_q = '{8'hB8, 8'h2B, 8'h18, 8'h00, 8'h14};
        foreach (pay_q[i]) lit_q.push_back(pay_q[i]);
        lit_q.push_back(8'hF0); lit_q.push_back(8'h00); lit_q.push_back(8'hFF);
        chk_lit("long24");

        // Long packet without payload.
        pay_q.delete();
        run_pkt(0, 1'b0, 8'h12, 16'h0000, -1, "long0");
        lit_q = '{8'hB8, 8'h12, 8'h00, 8'h00, ecc_model(8'h12, 16'h0000), 8'hFF, 8'hFF, 8'h00};
        chk_lit("long0");

        // Starved payload byte 3 of 8.
        fill_rand(8);
        run_pkt(0, 1'b0, 8'h2A, 16'd8, 2, "starve");

        // Random packets; underrun must stay latched.
        for (int r = 0; r < 8; r++) begin
            shrt = 1'($urandom);
            wc   = shrt ? 16'($urandom) : 16'($urandom_range(0, 40));
            fill_rand(int'(wc) + 1);
            run_pkt(0, shrt, 8'($urandom), wc, -1, $sformatf("rnd0_%0d", r));
        end

        // Reset in the middle of a payload.
        fill_rand(8);
        start[0] = 1'b1; short_pkt[0] = 1'b0; data_id[0] = 8'h3C; word_count[0] = 16'd8;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pl_valid[0] = 1'b1;
            pl_data[0]  = pay_q[i];
            @(negedge clk);
        end
        chk("pre_rst_pl_ready", pl_ready[0], 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle(0, "midrst0");
        chk_idle(1, "midrst1");
        rst_n = 1'b1;
        pl_valid[0] = 1'b0;
        ul_exp[0] = 0; ul_exp[1] = 0;
        @(negedge clk);
        run_pkt(0, 1'b1, 8'h00, 16'h0000, -1, "after_rst");
        lit_q = '{8'hB8, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        chk_lit("after_rst");

        // Two trail bytes, random traffic including an occasional starved byte.
        for (int r = 0; r < 6; r++) begin
            shrt = 1'($urandom);
            wc   = shrt ? 16'($urandom) : 16'($urandom_range(0, 30));
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
            fill_rand(int'(wc) + 1);
            run_pkt(1, shrt, 8'($urandom), wc, drop, $sformatf("rnd1_%0d", r));
        end

        run_b2b();
        chk("b2b_underrun", underrun[1], ul_exp[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
